// File: rtl/rr_burst_arbiter_pkg.sv
// Shared arbitration types and helpers: FSM state encoding, default sizes and
// a behavioural round-robin pick function usable by any arbiter in the tree.
package arb_pkg;

   localparam int ARB_N     = 4;
   localparam int ARB_WW    = 4;
   localparam int PICK_MAXN = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic       found;
      logic [4:0] idx;
   } pick_t;

   // First set bit of req scanning ptr, ptr+1, ... wrapping at n.
   function automatic pick_t rr_pick(input logic [PICK_MAXN-1:0] req,
                                     input int unsigned n,
                                     input int unsigned ptr);
      pick_t r;
      int unsigned j;
      r = '0;
      for (int k = PICK_MAXN - 1; k >= 0; k--) begin
         if (unsigned'(k) < n) begin
            j = ptr + unsigned'(k);
            if (j >= n) j = j - n;
            if (req[j[4:0]]) begin
               r.found = 1'b1;
               r.idx   = j[4:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin picker: rotate req so ptr lands at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick_comb #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           found,
   output logic [IDW-1:0] idx
);

   localparam logic [IDW:0] N_W = (IDW+1)'(N);

   logic [N-1:0]   rot;
   logic [IDW-1:0] off;
   logic [IDW:0]   sum;

   always_comb begin
      rot = N'({req, req} >> ptr);
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = IDW'(i);
      end
      found = |rot;
      sum   = {1'b0, ptr} + {1'b0, off};
      idx   = (sum >= N_W) ? IDW'(sum - N_W) : sum[IDW-1:0];
   end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Weighted round-robin arbiter granting one requester per burst; the grant is
// held until last beat, quota exhaustion, or request withdrawal.
module rr_burst_arbiter
   import arb_pkg::*;
#(
   parameter int N   = ARB_N,
   parameter int WW  = ARB_WW,
   parameter int IDW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    last,
   input  logic [N*WW-1:0] weight,
   input  logic            res_ready,
   output logic [N-1:0]    grant,
   output logic            gnt_valid,
   output logic [IDW-1:0]  gnt_id,
   output logic            beat
);

   localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

   state_t         state, state_nx;
   logic [IDW-1:0] ptr, ptr_nx, id_nx;
   logic [N-1:0]   grant_nx;
   logic [WW-1:0]  q, q_nx, cnt, cnt_nx, w_sel;
   logic [WW:0]    cnt_inc;
   logic           pick_found, rel;
   logic [IDW-1:0] pick_idx;

   rr_pick_comb #(.N(N), .IDW(IDW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Handshake: a beat moves when the grant is valid, the granted requester
   // has a beat (req) and the resource is ready; either side may stall.
   assign gnt_valid = |grant;
   assign beat      = gnt_valid & req[gnt_id] & res_ready;
   assign cnt_inc   = (WW+1)'(cnt) + (WW+1)'(1);

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (pick_idx == IDW'(i)) w_sel = weight[i*WW +: WW];
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      grant_nx = grant;
      id_nx    = gnt_id;
      q_nx     = q;
      cnt_nx   = cnt;
      rel      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               grant_nx = N'(1) << pick_idx;
               id_nx    = pick_idx;
               q_nx     = (w_sel == '0) ? WW'(1) : w_sel;
               cnt_nx   = '0;
               state_nx = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!req[gnt_id]) begin
               rel = 1'b1;
            end else if (beat) begin
               cnt_nx = cnt_inc[WW-1:0];
               if (last[gnt_id] || cnt_inc == {1'b0, q}) rel = 1'b1;
            end
            // The releasing requester drops to lowest priority.
            if (rel) begin
               grant_nx = '0;
               id_nx    = '0;
               ptr_nx   = (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
               state_nx = ST_IDLE;
            end
         end
         default: begin
            grant_nx = '0;
            id_nx    = '0;
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         ptr    <= '0;
         grant  <= '0;
         gnt_id <= '0;
         q      <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_nx;
         ptr    <= ptr_nx;
         grant  <= grant_nx;
         gnt_id <= id_nx;
         q      <= q_nx;
         cnt    <= cnt_nx;
      end
   end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Weighted round-robin arbiter that shares one downstream resource port between N requesters at burst granularity. Arbitration happens once per burst. The grant is then held until the winner signals its last beat, uses up its per-requester beat quota, or withdraws its request. It sits between the requester ports and the shared resource and generalises our single-cycle 4-way round-robin grant to multi-beat, quota-limited transfers with a ready handshake.

## Interface
Parameters:
- N, 4: number of requesters (≥2).
- WW, 4: width of each per-requester weight (beat quota) field.
- IDW, $clog2(N): width of gnt_id.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, N: req[i]=1 means requester i has a beat available.
- last, input, N: last[i] marks requester i's current beat as the final beat of its burst.
- weight, input, N*WW: packed quotas; field i is weight[i*WW +: WW]. A value of 0 is treated as 1.
- res_ready, input, 1: resource accepts a beat this cycle.
- grant, output, N: registered one-hot grant, or all zeros.
- gnt_valid, output, 1: equals |grant.
- gnt_id, output, IDW: index of the granted requester; 0 when no grant.
- beat, output, 1: a beat transfers this cycle; beat = gnt_valid & req[gnt_id] & res_ready.

## Operation
- Registered state: a two-state FSM {IDLE, BUSY}, a pointer ptr (IDW bits), the current quota q (WW bits), and a beat counter cnt (WW bits).
- Reset: state=IDLE, ptr=0, grant=0, gnt_id=0, cnt=0, q=0. beat is 0 because gnt_valid=0.
- IDLE:
  - If any req bit is set, pick the first requester with req set, scanning ptr, ptr+1, …, wrapping mod N.
  - Register grant to that requester's one-hot, gnt_id to its index, q=max(weight field,1) sampled at this edge, cnt=0. Go to BUSY.
  - If req=0, stay in IDLE with grant=0.
- BUSY: grant, gnt_id and q are frozen.
  - On a beat, cnt increments.
  - Release happens at the edge where any of these holds:
    - (a) a beat occurs with last[gnt_id]=1;
    - (b) a beat occurs with cnt+1 == q (quota exhausted);
    - (c) req[gnt_id]=0 (withdrawal; no beat that cycle).
  - Release action: grant=0, gnt_id=0, ptr=(gnt_id+1) mod N, state=IDLE.
  - (a) and (b) in the same cycle produce a single release.
- res_ready=0 in BUSY: the grant holds, cnt does not change, and there is no timeout.
- Weight changes take effect only at the next grant. q is never re-sampled mid-burst.
- Non-granted requesters' req and last bits are ignored while BUSY.
- Fairness: after a release, the releasing requester has the lowest priority at the next arbitration. A requester waits at most N−1 bursts.

## Timing
- Request-to-grant latency: 1 cycle. req[i] high in IDLE at edge k gives grant[i]=1 from edge k onward.
- The earliest beat is the first cycle grant is high. With res_ready and req held high, a burst of q beats occupies q consecutive cycles.
- Release edge: grant=0 for exactly one cycle (IDLE), then the next grant registers. Burst-to-burst gap is 1 idle cycle.
- Reset mid-burst: at the reset edge, all state returns to reset values and no beat is reported after it. An in-flight burst is abandoned.
- grant, gnt_valid and gnt_id are pure flops. beat is combinational from grant, req and res_ready.

## Structure
- Shared package arb_pkg:
  - FSM state enum (ST_IDLE, ST_BUSY);
  - default N/WW constants;
  - a function rr_pick(req, ptr) that returns the first-set index rotated from ptr, plus a found flag.
- One sub-module is natural: rr_pick_comb, a combinational rotate/priority-encode/rotate-back picker. It is reusable by other arbiters.
- The top holds the FSM, ptr, q/cnt counters and the release logic. Expected size is about 150–250 lines.

## Test plan
- Reset then single requester: req=0100, weight all 2, res_ready=1 → grant=0100 one cycle after req, 2 beats, release, 1 idle cycle, re-grant to 2, ptr=3.
- All request, weights {1,2,3,4} for req0..3, last never asserted, res_ready=1 → grant order 0,1,2,3,0 with 1,2,3,4 beats respectively, each burst followed by 1 idle cycle.
- Early last: req=0001, weight0=8, last[0] on the 3rd beat → exactly 3 beats, release, ptr=1.
- Backpressure: grant to 1 with q=4, res_ready toggling 1,0,0,1,1,0,1 → beats counted only on ready cycles, release after the 4th beat, grant stable throughout.
- Withdrawal and weight 0: req1 granted with weight1=0 → q=1, one beat then release. Separately, req2 drops after 1 of 4 beats → release at the drop edge, ptr=3.
- Reset mid-burst: rst asserted during beat 2 of 4 → grant=0, ptr=0 at that edge. After rst deasserts with req=1111, first grant=0001.
